// File: rtl/div_pkg.sv
// Shared constants for the sequential divider: FSM state encodings and default widths.
package div_pkg;

   localparam logic IDLE = 1'b0;
   localparam logic RUN  = 1'b1;

   localparam int unsigned DIVIDEND_W_DEF = 8;
   localparam int unsigned DIVISOR_W_DEF  = 4;

endpackage : div_pkg

// File: rtl/seq_divider.sv
// Restoring unsigned divider, one quotient bit per clock, start/busy/done handshake.
// Results are held on the outputs until the next operation completes.
module seq_divider
   import div_pkg::*;
#(
   parameter int unsigned DIVIDEND_W = DIVIDEND_W_DEF,
   parameter int unsigned DIVISOR_W  = DIVISOR_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [DIVIDEND_W-1:0] dividend,
   input  logic [DIVISOR_W-1:0]  divisor,
   output logic                  busy,
   output logic                  done,
   output logic [DIVIDEND_W-1:0] quotient,
   output logic [DIVISOR_W-1:0]  remainder,
   output logic                  div_zero
);

   localparam int unsigned CNT_W = $clog2(DIVIDEND_W);
   localparam int unsigned PR_W  = DIVISOR_W + 1;

   logic                  state_q,   state_d;
   logic [DIVIDEND_W-1:0] shift_q,   shift_d;
   logic [PR_W-1:0]       partial_q, partial_d;
   logic [DIVISOR_W-1:0]  dvs_q,     dvs_d;
   logic [CNT_W-1:0]      cnt_q,     cnt_d;
   logic                  busy_q,    busy_d;
   logic                  done_q,    done_d;
   logic [DIVIDEND_W-1:0] quot_q,    quot_d;
   logic [DIVISOR_W-1:0]  rem_q,     rem_d;
   logic                  dz_q,      dz_d;

   logic [PR_W:0]         step;
   logic [DIVIDEND_W-1:0] shift_next;

   // One restoring step: returns {quotient bit, next partial remainder}.
   function automatic logic [PR_W:0] div_step(input logic [PR_W-1:0]      partial,
                                              input logic                 msb,
                                              input logic [DIVISOR_W-1:0] dvs);
      logic [PR_W:0] trial;
      logic [PR_W:0] diff;
      trial = {partial, msb};
      diff  = trial - (PR_W+1)'(dvs);
      if (trial >= (PR_W+1)'(dvs)) begin
         div_step = {1'b1, diff[PR_W-1:0]};
      end else begin
         div_step = {1'b0, trial[PR_W-1:0]};
      end
   endfunction

   assign step       = div_step(partial_q, shift_q[DIVIDEND_W-1], dvs_q);
   assign shift_next = {shift_q[DIVIDEND_W-2:0], step[PR_W]};

   // Next-state and registered-output logic.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      partial_d = partial_q;
      dvs_d     = dvs_q;
      cnt_d     = cnt_q;
      busy_d    = busy_q;
      done_d    = 1'b0;
      quot_d    = quot_q;
      rem_d     = rem_q;
      dz_d      = dz_q;

      if (state_q == IDLE) begin
         if (start) begin
            if (divisor != '0) begin
               shift_d   = dividend;
               dvs_d     = divisor;
               partial_d = '0;
               cnt_d     = CNT_W'(DIVIDEND_W - 1);
               busy_d    = 1'b1;
               state_d   = RUN;
            end else begin
               quot_d = '1;
               rem_d  = '0;
               dz_d   = 1'b1;
               done_d = 1'b1;
            end
         end
      end else begin
         partial_d = step[PR_W-1:0];
         shift_d   = shift_next;
         cnt_d     = cnt_q - CNT_W'(1);
         if (cnt_q == '0) begin
            quot_d  = shift_next;
            rem_d   = step[DIVISOR_W-1:0];
            dz_d    = 1'b0;
            done_d  = 1'b1;
            busy_d  = 1'b0;
            state_d = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         partial_q <= '0;
         dvs_q     <= '0;
         cnt_q     <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
         quot_q    <= '0;
         rem_q     <= '0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         partial_q <= partial_d;
         dvs_q     <= dvs_d;
         cnt_q     <= cnt_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
         quot_q    <= quot_d;
         rem_q     <= rem_d;
         dz_q      <= dz_d;
      end
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign div_zero  = dz_q;

endmodule : seq_divider

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: directed handshake cases plus random operands
// compared against plain integer division.
module tb_seq_divider;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic [7:0] dividend;
   logic [3:0] divisor;
   logic       busy;
   logic       done;
   logic [7:0] quotient;
   logic [3:0] remainder;
   logic       div_zero;

   int checks = 0;
   int errors = 0;

   seq_divider #(.DIVIDEND_W(8), .DIVISOR_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .dividend  (dividend),
      .divisor   (divisor),
      .busy      (busy),
      .done      (done),
      .quotient  (quotient),
      .remainder (remainder),
      .div_zero  (div_zero)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Issue one operation from a negedge; returns at the negedge where done is seen.
   task automatic do_div(input logic [7:0] a, input logic [3:0] b, input bit hold, input int poke);
      logic [7:0] q0;
      logic [3:0] r0;
      logic       dz0;
      int         edges;
      int         bcnt;
      bit         unstable;
      bit         seen;
      int         exp_q;
      int         exp_r;
      q0 = quotient; r0 = remainder; dz0 = div_zero;
      start = 1'b1; dividend = a; divisor = b;
      @(posedge clk); #1;
      if (!hold) start = 1'b0;
      dividend = 8'($urandom);
      divisor  = 4'($urandom);
      edges = 0; bcnt = 0; unstable = 1'b0; seen = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) begin
            seen = 1'b1;
            break;
         end
         if (busy) bcnt++;
         if (quotient !== q0 || remainder !== r0 || div_zero !== dz0) unstable = 1'b1;
         if (poke > 0 && edges == poke) begin
            start = 1'b1; dividend = 8'($urandom); divisor = 4'($urandom_range(15, 1));
         end else if (poke > 0 && edges == poke + 1) begin
            start = 1'b0;
         end
         @(posedge clk);
         edges++;
      end
      check("done_seen", 32'(seen), 1);
      check("busy_at_done", 32'(busy), 0);
      check("outputs_stable", 32'(unstable), 0);
      if (b == 0) begin
         exp_q = 255; exp_r = 0;
         check("zero_latency", 32'(edges), 0);
         check("zero_busy", 32'(bcnt), 0);
      end else begin
         exp_q = int'(a) / int'(b);
         exp_r = int'(a) % int'(b);
         check("latency", 32'(edges), 8);
         check("busy_cycles", 32'(bcnt), 8);
      end
      check("quotient", 32'(quotient), 32'(exp_q));
      check("remainder", 32'(remainder), 32'(exp_r));
      check("div_zero", 32'(div_zero), (b == 0) ? 1 : 0);
   endtask

   initial begin
      rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
      repeat (2) @(negedge clk);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(done), 0);
      check("rst_quotient", 32'(quotient), 0);
      check("rst_remainder", 32'(remainder), 0);
      check("rst_div_zero", 32'(div_zero), 0);
      rst = 1'b1;
      @(negedge clk);

      do_div(8'hB6, 4'hA, 1'b0, 0);
      @(negedge clk);
      check("done_one_cycle", 32'(done), 0);
      check("quotient_held", 32'(quotient), 18);
      check("remainder_held", 32'(remainder), 2);

      for (int n = 0; n <= 100; n++) do_div(8'(n), 4'd10, 1'b0, 0);

      do_div(8'd255, 4'd1, 1'b0, 0);
      do_div(8'd255, 4'd15, 1'b0, 0);
      do_div(8'd0, 4'd7, 1'b0, 0);

      do_div(8'd42, 4'd0, 1'b0, 0);
      do_div(8'd50, 4'd7, 1'b0, 0);

      do_div(8'd100, 4'd10, 1'b0, 3);

      do_div(8'd100, 4'd10, 1'b0, 0);
      do_div(8'd37, 4'd5, 1'b0, 0);

      do_div(8'd200, 4'd9, 1'b1, 0);
      do_div(8'd201, 4'd9, 1'b1, 0);
      do_div(8'd77, 4'd3, 1'b0, 0);

      // Abandon an in-flight 182/10 with an asynchronous reset between edges.
      do_div(8'd60, 4'd7, 1'b0, 0);
      start = 1'b1; dividend = 8'd182; divisor = 4'd10;
      @(posedge clk); #1; start = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst = 1'b0;
      #1;
      check("async_busy", 32'(busy), 0);
      check("async_quotient", 32'(quotient), 0);
      check("async_remainder", 32'(remainder), 0);
      check("async_div_zero", 32'(div_zero), 0);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_no_done", 32'(done), 0);
      end
      rst = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("post_rst_idle_done", 32'(done), 0);
      end
      do_div(8'd56, 4'd10, 1'b0, 0);

      for (int i = 0; i < 60; i++) do_div(8'($urandom), 4'($urandom_range(15, 0)), 1'b0, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_seq_divider
